matrix_pack_buffer: RTL and testbench
=====================================

MATRIX_PACK_BUFFER -- requirements
Module: matrix_pack_buffer

Interface
REQ-001 SHALL have parameter ELEM_W, default 8: element width in bits.
REQ-002 SHALL have parameter MAX_N, default 5: maximum matrix dimension; bus width BUS_W = MAX_N*MAX_N*ELEM_W (200 at defaults).
REQ-003 SHALL have port clk  input  1: single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: compact matrices and size offered.
REQ-006 SHALL have port in_ready  output  1: block can accept.
REQ-007 SHALL have port size  input  $clog2(MAX_N+1): matrix dimension N.
REQ-008 SHALL have ports matrix_a_in, matrix_b_in  input  BUS_W: compact row-major, element k=r*N+c at bits [BUS_W-1-k*ELEM_W -: ELEM_W].
REQ-009 SHALL have ports matrix_a_out, matrix_b_out  output  BUS_W: expanded layout, element (r,c) in slot r*MAX_N+c, same MSB-first slot indexing.
REQ-010 SHALL have port out_valid  output  1: expanded matrices valid.
REQ-011 SHALL have port out_ready  input  1: consumer accepts.
REQ-012 SHALL have port size_err  output  1: last accepted size was illegal.

Function
REQ-013 SHALL implement FSM states IDLE, UNPACK, HOLD.
REQ-014 IDLE SHALL drive in_ready=1; in_valid=1 SHALL capture size, both inputs (and b_transpose if built), zero both output registers, row counter=0.
REQ-015 Legal size (1..MAX_N) SHALL go IDLE->UNPACK; illegal (0 or >MAX_N) SHALL go IDLE->HOLD with size_err=1, outputs all zero.
REQ-016 UNPACK SHALL write one row (N elements) per cycle into both outputs, row counter incrementing; row N-1 SHALL transition to HOLD.
REQ-017 out_valid SHALL rise exactly N cycles after the accepting edge for legal sizes, 1 cycle for illegal.
REQ-018 Slots with r>=N or c>=N SHALL read zero.
REQ-019 HOLD SHALL drive out_valid=1 with outputs and size_err stable until out_ready=1, then return to IDLE.
REQ-020 in_ready SHALL be 0 in UNPACK and HOLD; in_valid there SHALL be ignored (no same-cycle handoff).
REQ-021 size_err SHALL update only at acceptance.
REQ-022 Outputs SHALL be registered; no combinational path input->output.

Reset
REQ-023 rst_n low SHALL force IDLE, row counter 0, in_ready 1 after release, out_valid 0, size_err 0, both outputs zero, at any time including mid-UNPACK.

Configuration
REQ-024 With MATRIX_BUF_TRANSPOSE_EN defined, SHALL add input b_transpose (1 bit), captured at acceptance; when 1, B element (r,c) SHALL land in slot c*MAX_N+r.
REQ-025 Without MATRIX_BUF_TRANSPOSE_EN, port b_transpose SHALL not exist and B SHALL use the same mapping as A.

Structure
REQ-026 Package matrix_buf_pkg SHALL hold the FSM state typedef, default ELEM_W/MAX_N constants, and the slot-index function.
REQ-027 Sub-module matrix_row_unpack SHALL extract row r of a compact bus for dimension N as MAX_N elements, zero-padded; instantiated once per matrix.

Verification
REQ-028 size=3, A elements 1..9, B 9..1 -> out_valid 3 cycles after accept; A rows 01 02 03 00 00 / 04 05 06 00 00 / 07 08 09 00 00, rest zero.
REQ-029 size=5, elements 1..25 -> out_valid after 5 cycles, output equals input bitwise.
REQ-030 size=0 and size=6 -> out_valid after 1 cycle, size_err=1, outputs zero; next legal transfer clears size_err.
REQ-031 size=2, out_ready held 0 for 10 cycles, in_valid pulsed meanwhile -> outputs stable, in_ready 0, second offer not taken until after out_ready handshake.
REQ-032 rst_n pulsed low mid-UNPACK of size 4 -> out_valid 0, outputs zero, IDLE; next size=2 transfer completes correctly.
REQ-033 MATRIX_BUF_TRANSPOSE_EN, size=3, b_transpose=1, B=1..9 -> B rows 01 04 07 / 02 05 08 / 03 06 09; A unchanged.

Source files
------------

// File: rtl/matrix_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_buf_pkg
// Description : Shared FSM state type, default dimensions and slot mapping
//               for matrix_pack_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_buf_pkg;

  localparam int c_DEF_ELEM_W = 8;
  localparam int c_DEF_MAX_N  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Expanded-layout slot of element (r,c); slot 0 is the most significant.
  function automatic int slot_index(input int r, input int c, input int max_n);
    return r * max_n + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_row_unpack.sv
`default_nettype none
// ============================================================================
// Module      : matrix_row_unpack
// Description : Extracts row r of an N x N compact row-major bus as MAX_N
//               elements, MSB-first, zero-padded for columns c >= N.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_row_unpack #(
  parameter  int ELEM_W = 8,
  parameter  int MAX_N  = 5,
  localparam int BUS_W  = MAX_N * MAX_N * ELEM_W,
  localparam int SZ_W   = $clog2(MAX_N + 1),
  localparam int ROW_W  = MAX_N * ELEM_W
) (
  input  logic [BUS_W-1:0] bus,
  input  logic [SZ_W-1:0]  n,
  input  logic [SZ_W-1:0]  row,
  output logic [ROW_W-1:0] row_elems
);

  for (genvar c = 0; c < MAX_N; c++) begin : g_col
    logic [ELEM_W-1:0] w_elem;
    int                w_k;

    always_comb begin
      w_k    = int'(row) * int'(n) + c;
      w_elem = '0;
      if ((c < int'(n)) && (w_k < MAX_N * MAX_N)) begin
        w_elem = bus[BUS_W-1-w_k*ELEM_W -: ELEM_W];
      end
    end

    assign row_elems[ROW_W-1-c*ELEM_W -: ELEM_W] = w_elem;
  end : g_col

endmodule
`default_nettype wire

// File: rtl/matrix_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pack_buffer
// Description : Captures two compact N x N matrices and expands them, one row
//               per cycle, into fixed MAX_N x MAX_N slot layouts.
//               Optional feature macro: MATRIX_BUF_TRANSPOSE_EN (adds
//               b_transpose, which stores B transposed).
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_pack_buffer
  import matrix_buf_pkg::*;
#(
  parameter  int ELEM_W = c_DEF_ELEM_W,
  parameter  int MAX_N  = c_DEF_MAX_N,
  localparam int BUS_W  = MAX_N * MAX_N * ELEM_W,
  localparam int SZ_W   = $clog2(MAX_N + 1),
  localparam int ROW_W  = MAX_N * ELEM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SZ_W-1:0]  size,
  input  logic [BUS_W-1:0] matrix_a_in,
  input  logic [BUS_W-1:0] matrix_b_in,
`ifdef MATRIX_BUF_TRANSPOSE_EN
  input  logic             b_transpose,
`endif
  output logic [BUS_W-1:0] matrix_a_out,
  output logic [BUS_W-1:0] matrix_b_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             size_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SZ_W-1:0]  r_size;
  logic [SZ_W-1:0]  r_row;
  logic [BUS_W-1:0] r_a_cmp;
  logic [BUS_W-1:0] r_b_cmp;
  logic [BUS_W-1:0] r_a_out;
  logic [BUS_W-1:0] r_b_out;
  logic             r_size_err;
`ifdef MATRIX_BUF_TRANSPOSE_EN
  logic             r_b_tr;
`endif

  logic [ROW_W-1:0] w_a_row;
  logic [ROW_W-1:0] w_b_row;
  logic [BUS_W-1:0] w_a_nxt;
  logic [BUS_W-1:0] w_b_nxt;
  logic             w_accept;
  logic             w_size_ok;
  logic             w_last_row;
  int               w_slot_a;
  int               w_slot_b;

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == HOLD);
  assign size_err     = r_size_err;
  assign matrix_a_out = r_a_out;
  assign matrix_b_out = r_b_out;

  assign w_accept   = in_ready && in_valid;
  assign w_size_ok  = (size != '0) && (size <= SZ_W'(MAX_N));
  assign w_last_row = (r_row == (r_size - SZ_W'(1)));

  matrix_row_unpack #(.ELEM_W(ELEM_W), .MAX_N(MAX_N)) u_row_a (
    .bus       (r_a_cmp),
    .n         (r_size),
    .row       (r_row),
    .row_elems (w_a_row)
  );

  matrix_row_unpack #(.ELEM_W(ELEM_W), .MAX_N(MAX_N)) u_row_b (
    .bus       (r_b_cmp),
    .n         (r_size),
    .row       (r_row),
    .row_elems (w_b_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_size_ok ? UNPACK : HOLD;
      UNPACK:  if (w_last_row) w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Merge the current row into the output images; untouched slots keep the
  // zeros loaded at acceptance, which provides the padding for r,c >= N.
  always_comb begin
    w_a_nxt  = r_a_out;
    w_b_nxt  = r_b_out;
    w_slot_a = 0;
    w_slot_b = 0;
    for (int c = 0; c < MAX_N; c++) begin
      w_slot_a = slot_index(int'(r_row), c, MAX_N);
`ifdef MATRIX_BUF_TRANSPOSE_EN
      w_slot_b = r_b_tr ? slot_index(c, int'(r_row), MAX_N) : w_slot_a;
`else
      w_slot_b = w_slot_a;
`endif
      if (w_slot_a < MAX_N * MAX_N) begin
        w_a_nxt[BUS_W-1-w_slot_a*ELEM_W -: ELEM_W] = w_a_row[ROW_W-1-c*ELEM_W -: ELEM_W];
      end
      if (w_slot_b < MAX_N * MAX_N) begin
        w_b_nxt[BUS_W-1-w_slot_b*ELEM_W -: ELEM_W] = w_b_row[ROW_W-1-c*ELEM_W -: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size     <= '0;
      r_row      <= '0;
      r_a_cmp    <= '0;
      r_b_cmp    <= '0;
      r_a_out    <= '0;
      r_b_out    <= '0;
      r_size_err <= 1'b0;
`ifdef MATRIX_BUF_TRANSPOSE_EN
      r_b_tr     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_size     <= size;
      r_row      <= '0;
      r_a_cmp    <= matrix_a_in;
      r_b_cmp    <= matrix_b_in;
      r_a_out    <= '0;
      r_b_out    <= '0;
      r_size_err <= !w_size_ok;
`ifdef MATRIX_BUF_TRANSPOSE_EN
      r_b_tr     <= b_transpose;
`endif
    end else if (r_state == UNPACK) begin
      r_a_out <= w_a_nxt;
      r_b_out <= w_b_nxt;
      r_row   <= r_row + SZ_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_pack_buffer
// Description : Scoreboard bench for matrix_pack_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_pack_buffer;

  localparam int ELEM_W = 8;
  localparam int MAX_N  = 5;
  localparam int BUS_W  = MAX_N * MAX_N * ELEM_W;
  localparam int SZ_W   = $clog2(MAX_N + 1);

  typedef struct {
    logic [BUS_W-1:0] a;
    logic [BUS_W-1:0] b;
    logic             err;
    int               lat;
  } exp_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [SZ_W-1:0]  size      = '0;
  logic [BUS_W-1:0] a_in      = '0;
  logic [BUS_W-1:0] b_in      = '0;
`ifdef MATRIX_BUF_TRANSPOSE_EN
  logic             b_transpose = 1'b0;
`endif
  logic             in_ready;
  logic             out_valid;
  logic             size_err;
  logic [BUS_W-1:0] a_out;
  logic [BUS_W-1:0] b_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t last_exp;

  matrix_pack_buffer #(.ELEM_W(ELEM_W), .MAX_N(MAX_N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .size         (size),
    .matrix_a_in  (a_in),
    .matrix_b_in  (b_in),
`ifdef MATRIX_BUF_TRANSPOSE_EN
    .b_transpose  (b_transpose),
`endif
    .matrix_a_out (a_out),
    .matrix_b_out (b_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .size_err     (size_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] pack_seq(input int n, input int start, input int step);
    logic [BUS_W-1:0] v;
    v = '0;
    for (int k = 0; k < n * n; k++) v[BUS_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(start + step * k);
    return v;
  endfunction

  // Reference expansion: compact element k=r*N+c lands in slot r*MAX_N+c
  // (or c*MAX_N+r when transposed); illegal sizes produce all zeros.
  function automatic logic [BUS_W-1:0] expand(input logic [BUS_W-1:0] cmp, input int n, input bit tr);
    logic [BUS_W-1:0] res;
    int k;
    int s;
    res = '0;
    if (n >= 1 && n <= MAX_N) begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          k = r * n + c;
          s = tr ? (c * MAX_N + r) : (r * MAX_N + c);
          res[BUS_W-1-s*ELEM_W -: ELEM_W] = cmp[BUS_W-1-k*ELEM_W -: ELEM_W];
        end
      end
    end
    return res;
  endfunction

  task automatic offer(input int n, input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b, input bit tr);
    exp_t e;
    int   cnt;
    bit   legal;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("in_ready_offer", BUS_W'(in_ready), BUS_W'(1));
    size     = SZ_W'(n);
    a_in     = a;
    b_in     = b;
`ifdef MATRIX_BUF_TRANSPOSE_EN
    b_transpose = tr;
`endif
    in_valid = 1'b1;
    legal    = (n >= 1) && (n <= MAX_N);
    e.a      = expand(a, n, 1'b0);
    e.b      = expand(b, n, tr);
    e.err    = !legal;
    e.lat    = legal ? n : 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
    end while (!out_valid && cnt < 40);
    e = sb.pop_front();
    last_exp = e;
    check_eq("latency", BUS_W'(cnt), BUS_W'(e.lat));
    check_eq("a_out", a_out, e.a);
    check_eq("b_out", b_out, e.b);
    check_eq("size_err", BUS_W'(size_err), BUS_W'(e.err));
    check_eq("in_ready_busy", BUS_W'(in_ready), BUS_W'(0));
  endtask

  task automatic hold_check(input int cycles, input bit pulse);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (pulse && (i == 3 || i == 4)) begin
        size     = SZ_W'(2);
        a_in     = pack_seq(2, 'h40, 1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check_eq("hold_valid", BUS_W'(out_valid), BUS_W'(1));
      check_eq("hold_in_ready", BUS_W'(in_ready), BUS_W'(0));
      check_eq("hold_a", a_out, last_exp.a);
      check_eq("hold_b", b_out, last_exp.b);
      check_eq("hold_err", BUS_W'(size_err), BUS_W'(last_exp.err));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("release_valid", BUS_W'(out_valid), BUS_W'(0));
    check_eq("release_in_ready", BUS_W'(in_ready), BUS_W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", BUS_W'(out_valid), BUS_W'(0));
    check_eq("rst_size_err", BUS_W'(size_err), BUS_W'(0));
    check_eq("rst_a", a_out, '0);
    check_eq("rst_b", b_out, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", BUS_W'(in_ready), BUS_W'(1));

    offer(3, pack_seq(3, 1, 1), pack_seq(3, 9, -1), 1'b0);
    check_eq("n3_a_literal", a_out,
             200'h0102030000_0405060000_0708090000_0000000000_0000000000);
    hold_check(2, 1'b0);
    release_out();

    offer(5, pack_seq(5, 1, 1), pack_seq(5, 25, -1), 1'b0);
    check_eq("n5_a_identity", a_out, pack_seq(5, 1, 1));
    check_eq("n5_b_identity", b_out, pack_seq(5, 25, -1));
    release_out();

    offer(0, pack_seq(3, 1, 1), pack_seq(3, 1, 1), 1'b0);
    release_out();
    offer(6, pack_seq(5, 7, 3), pack_seq(5, 2, 5), 1'b0);
    release_out();
    offer(1, pack_seq(1, 'hA5, 0), pack_seq(1, 'h5A, 0), 1'b0);
    release_out();
    offer(4, pack_seq(4, 'h10, 1), pack_seq(4, 'h80, 2), 1'b0);
    release_out();

    offer(2, pack_seq(2, 'hC1, 1), pack_seq(2, 'hD1, 1), 1'b0);
    hold_check(10, 1'b1);
    release_out();
    @(negedge clk);
    check_eq("no_late_capture", BUS_W'(in_ready), BUS_W'(1));

    size     = SZ_W'(4);
    a_in     = pack_seq(4, 1, 1);
    b_in     = pack_seq(4, 1, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", BUS_W'(out_valid), BUS_W'(0));
    check_eq("midrst_a", a_out, '0);
    check_eq("midrst_b", b_out, '0);
    check_eq("midrst_in_ready", BUS_W'(in_ready), BUS_W'(1));
    check_eq("midrst_size_err", BUS_W'(size_err), BUS_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    offer(2, pack_seq(2, 'h21, 1), pack_seq(2, 'h31, 1), 1'b0);
    release_out();

`ifdef MATRIX_BUF_TRANSPOSE_EN
    offer(3, pack_seq(3, 1, 1), pack_seq(3, 1, 1), 1'b1);
    check_eq("tr_b_literal", b_out,
             200'h0104070000_0205080000_0306090000_0000000000_0000000000);
    check_eq("tr_a_literal", a_out,
             200'h0102030000_0405060000_0708090000_0000000000_0000000000);
    release_out();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
